// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches 16-bit words in pairs over a simple
// request/ready bus and presents them to the decoder as a DEPTH-entry 32-bit FIFO.
module prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [15:0]              flush_addr,
    output logic                     mem_req,
    output logic [15:0]              mem_addr,
    input  logic                     mem_ready,
    input  logic [15:0]              mem_data,
    output logic                     ir_valid,
    output logic [31:0]              ir,
    output logic [15:0]              ir_pc,
    input  logic                     ir_take,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     lo_q, lo_d;
    logic [15:0]     lo_pc_q, lo_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     ent_q [DEPTH];
    logic [15:0]     pc_q  [DEPTH];
    logic            push;
    logic            pop;

    // flush masks both handshakes so a coincident word or take is dropped
    assign pop  = (count_q != '0) && ir_take && !flush;
    assign push = (state_q == FETCH_HI) && mem_ready && !flush;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        lo_d     = lo_q;
        lo_pc_d  = lo_pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            state_d  = FETCH_LO;
            addr_d   = flush_addr;
            lo_d     = '0;
            lo_pc_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (count_q < DEPTH_C) begin
                        state_d = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_ready) begin
                        lo_d    = mem_data;
                        lo_pc_d = addr_q;
                        addr_d  = addr_q + 16'd1;
                        state_d = FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    // post-push occupancy decides whether another fetch may start
                    if (mem_ready) begin
                        addr_d  = addr_q + 16'd1;
                        state_d = (count_d < DEPTH_C) ? FETCH_LO : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= RESET_PC;
            lo_q     <= '0;
            lo_pc_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lo_q     <= lo_d;
            lo_pc_q  <= lo_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                ent_q[wr_ptr_q] <= {mem_data, lo_q};
                pc_q[wr_ptr_q]  <= lo_pc_q;
            end
        end
    end

    assign mem_req  = (state_q != IDLE);
    assign mem_addr = addr_q;
    assign count    = count_q;
    assign ir_valid = (count_q != '0);
    assign ir       = ent_q[rd_ptr_q];
    assign ir_pc    = pc_q[rd_ptr_q];

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: a queue model of the decoder-visible instruction stream,
// fed by the words the bench returns on the bus, checked every cycle by a monitor.
module tb_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] flush_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic        ir_valid;
    logic [31:0] ir;
    logic [15:0] ir_pc;
    logic        ir_take;
    logic [2:0]  count;

    logic        dmode;
    logic [15:0] rnd_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] ir;
        logic [15:0] pc;
    } ent_t;

    ent_t        sbq[$];
    ent_t        e;
    logic        half;
    logic [15:0] lo_word;
    logic [15:0] lo_pc;
    logic [15:0] exp_addr;
    logic        prev_wait;
    logic        take_ok;

    prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .flush_addr (flush_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .ir_valid   (ir_valid),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_take    (ir_take),
        .count      (count)
    );

    always #5 clk = ~clk;

    // address-patterned memory for directed fills: word a holds nibble(a) x4 + 16'h1111
    always_comb begin
        mem_data = rnd_data;
        if (dmode) mem_data = {4{mem_addr[3:0]}} + 16'h1111;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: compare DUT against the model, then apply this edge's events to the model
    always @(negedge clk) begin
        if (!reset) begin
            sbq.delete();
            half      = 1'b0;
            exp_addr  = RESET_PC;
            prev_wait = 1'b0;
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'(RESET_PC));
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_ir_valid", 32'(ir_valid), 32'd0);
            chk("rst_ir", ir, 32'h0);
            chk("rst_ir_pc", 32'(ir_pc), 32'h0);
        end else begin
            chk("count", 32'(count), 32'(sbq.size()));
            chk("ir_valid", 32'(ir_valid), 32'(sbq.size() != 0));
            if (sbq.size() != 0) begin
                chk("head_ir", ir, sbq[0].ir);
                chk("head_pc", 32'(ir_pc), 32'(sbq[0].pc));
            end
            if (sbq.size() == DEPTH) chk("full_no_req", 32'(mem_req), 32'd0);
            if (mem_req) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            if (prev_wait) chk("req_hold", 32'(mem_req), 32'd1);

            if (flush) begin
                sbq.delete();
                half      = 1'b0;
                exp_addr  = flush_addr;
                prev_wait = 1'b0;
            end else begin
                take_ok = (sbq.size() != 0) && ir_take;
                if (take_ok) void'(sbq.pop_front());
                if (mem_req && mem_ready) begin
                    if (!half) begin
                        lo_word = mem_data;
                        lo_pc   = exp_addr;
                        half    = 1'b1;
                    end else begin
                        e.ir = {mem_data, lo_word};
                        e.pc = lo_pc;
                        sbq.push_back(e);
                        half = 1'b0;
                    end
                    exp_addr = exp_addr + 16'd1;
                end
                prev_wait = mem_req && !mem_ready;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int n, input int take_mod);
        for (int i = 0; i < n; i++) begin
            step();
            mem_ready = ($urandom % 3) != 0;
            ir_take   = ($urandom % take_mod) == 0;
            rnd_data  = 16'($urandom);
            flush     = ($urandom % 40) == 0;
            case ($urandom % 3)
                0:       flush_addr = 16'hFFFF;
                1:       flush_addr = 16'hFFFE;
                default: flush_addr = 16'($urandom);
            endcase
        end
        step();
        flush   = 1'b0;
        ir_take = 1'b0;
    endtask

    initial begin
        int cyc;
        reset      = 1'b0;
        flush      = 1'b0;
        flush_addr = 16'h0;
        mem_ready  = 1'b0;
        ir_take    = 1'b0;
        rnd_data   = 16'h0;
        dmode      = 1'b1;
        repeat (3) step();

        // basic fetch and fill to full
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("idle_after_rst", 32'(mem_req), 32'd0);
        step();
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'h0);
        cyc = 0;
        while (count != 3'd4 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("fill_count", 32'(count), 32'd4);
        step();
        chk("full_idle", 32'(mem_req), 32'd0);
        chk("first_ir", ir, 32'h2222_1111);
        chk("first_ir_pc", 32'(ir_pc), 32'h0);

        // one pop from full resumes fetching at word 8
        ir_take = 1'b1;
        step();
        ir_take = 1'b0;
        chk("pop_count", 32'(count), 32'd3);
        cyc = 0;
        while (!mem_req && cyc < 5) begin
            step();
            cyc++;
        end
        chk("resume_req", 32'(mem_req), 32'd1);
        chk("resume_addr", 32'(mem_addr), 32'h8);

        // wrap across the halves of one instruction
        dmode      = 1'b0;
        mem_ready  = 1'b0;
        flush      = 1'b1;
        flush_addr = 16'hFFFF;
        step();
        flush     = 1'b0;
        mem_ready = 1'b1;
        rnd_data  = 16'hAAAA;
        step();
        rnd_data = 16'hBBBB;
        step();
        mem_ready = 1'b0;
        chk("wrap_count", 32'(count), 32'd1);
        chk("wrap_ir", ir, 32'hBBBB_AAAA);
        chk("wrap_ir_pc", 32'(ir_pc), 32'hFFFF);
        chk("wrap_next_addr", 32'(mem_addr), 32'h0001);

        // flush during the high half drops the word and the take
        mem_ready = 1'b1;
        rnd_data  = 16'h1234;
        step();
        flush      = 1'b1;
        flush_addr = 16'h0040;
        rnd_data   = 16'h5678;
        ir_take    = 1'b1;
        step();
        flush     = 1'b0;
        ir_take   = 1'b0;
        mem_ready = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_ir_valid", 32'(ir_valid), 32'd0);
        chk("flush_addr", 32'(mem_addr), 32'h0040);
        chk("flush_req", 32'(mem_req), 32'd1);

        run_random(1500, 4);
        run_random(1500, 2);

        // asynchronous reset while a fetch is in progress with a non-empty queue
        mem_ready  = 1'b0;
        flush      = 1'b1;
        flush_addr = 16'h0100;
        step();
        flush     = 1'b0;
        mem_ready = 1'b1;
        rnd_data  = 16'hC0DE;
        step();
        rnd_data = 16'hBEEF;
        step();
        mem_ready = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_mem_req", 32'(mem_req), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_ir_valid", 32'(ir_valid), 32'd0);
        repeat (2) step();
        reset = 1'b1;

        run_random(500, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
